// File: rtl/sm4_uart_pkg.sv
// Shared constants and types for the UART-to-SM4 frame path: header bytes,
// block type tags, error codes, framer states and the timeout sizing helper.
package sm4_uart_pkg;

  localparam logic [7:0] HDR_KEY_DEF = 8'hA5;
  localparam logic [7:0] HDR_ENC_DEF = 8'h5A;
  localparam logic [7:0] HDR_DEC_DEF = 8'h3C;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_KEY  = 2'b01;
  localparam logic [1:0] TYPE_ENC  = 2'b10;
  localparam logic [1:0] TYPE_DEC  = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HDR     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam int TIMER_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One byte time on the wire is 10 bit times (start + 8 data + stop).
  function automatic int calc_timeout_cyc(input int clk_f, input int baud, input int nbytes);
    return nbytes * 10 * (clk_f / baud);
  endfunction

endpackage

// File: rtl/sm4_byte_timeout.sv
// Inter-byte silence timer: counts while enabled, restarts on clear, and
// flags expiry when the count reaches TIMEOUT_CYC-1 without a clear.
module sm4_byte_timeout
  import sm4_uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 208320
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] cnt_reg;

  // A clear in the expiry cycle wins, so a late byte still lands in the frame.
  assign expire = enable && !clear && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!enable || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg != LAST_CNT) begin
      cnt_reg <= cnt_reg + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/sm4_rx_framer.sv
// Parses header + 16-byte frames from the UART byte stream into tagged
// 128-bit blocks for the SM4 core; bad, stalled or overrun frames pulse frame_err.
module sm4_rx_framer
  import sm4_uart_pkg::*;
#(
  parameter int         CLK_F         = 50000000,
  parameter int         UART_B        = 9600,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] HDR_KEY       = HDR_KEY_DEF,
  parameter logic [7:0] HDR_ENC       = HDR_ENC_DEF,
  parameter logic [7:0] HDR_DEC       = HDR_DEC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_pdata,
  input  logic         rx_pdvalid,
  output logic [127:0] out_data,
  output logic [1:0]   out_type,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic         busy
);

  localparam int TIMEOUT_CYC = calc_timeout_cyc(CLK_F, UART_B, TIMEOUT_BYTES);

  state_t         state_reg, state_next;
  logic [1:0]     type_reg, type_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [119:0]   shift_reg, shift_next;
  logic [127:0]   out_data_reg, out_data_next;
  logic [1:0]     out_type_reg, out_type_next;
  logic           out_valid_reg, out_valid_next;
  logic           frame_err_reg, frame_err_next;
  logic [1:0]     err_code_reg, err_code_next;
  logic           pdvalid_prev_reg;

  logic           accept;
  logic           expire;
  logic           take_hdr;
  logic [1:0]     hdr_type;

  assign accept = rx_pdvalid && !pdvalid_prev_reg;

  sm4_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state_reg == RECV),
    .expire (expire)
  );

  always_comb begin
    hdr_type = TYPE_NONE;
    if (rx_pdata == HDR_KEY)      hdr_type = TYPE_KEY;
    else if (rx_pdata == HDR_ENC) hdr_type = TYPE_ENC;
    else if (rx_pdata == HDR_DEC) hdr_type = TYPE_DEC;
  end

  // A byte arriving in the handshake cycle of HOLD is treated as a fresh header.
  assign take_hdr = accept && ((state_reg == IDLE) || ((state_reg == HOLD) && out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      type_reg         <= TYPE_NONE;
      cnt_reg          <= '0;
      shift_reg        <= '0;
      out_data_reg     <= '0;
      out_type_reg     <= TYPE_NONE;
      out_valid_reg    <= 1'b0;
      frame_err_reg    <= 1'b0;
      err_code_reg     <= ERR_NONE;
      pdvalid_prev_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      type_reg         <= type_next;
      cnt_reg          <= cnt_next;
      shift_reg        <= shift_next;
      out_data_reg     <= out_data_next;
      out_type_reg     <= out_type_next;
      out_valid_reg    <= out_valid_next;
      frame_err_reg    <= frame_err_next;
      err_code_reg     <= err_code_next;
      pdvalid_prev_reg <= rx_pdvalid;
    end
  end

  always_comb begin
    state_next     = state_reg;
    type_next      = type_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    out_data_next  = out_data_reg;
    out_type_next  = out_type_reg;
    out_valid_next = out_valid_reg;
    frame_err_next = 1'b0;
    err_code_next  = err_code_reg;

    case (state_reg)
      RECV: begin
        if (accept) begin
          shift_next = {shift_reg[111:0], rx_pdata};
          if (cnt_reg == 4'd15) begin
            out_data_next  = {shift_reg, rx_pdata};
            out_type_next  = type_reg;
            out_valid_next = 1'b1;
            state_next     = HOLD;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end else if (expire) begin
          frame_err_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
          state_next     = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          out_type_next  = TYPE_NONE;
          state_next     = IDLE;
        end else if (accept) begin
          frame_err_next = 1'b1;
          err_code_next  = ERR_OVERRUN;
        end
      end
      default: ;
    endcase

    if (take_hdr) begin
      if (hdr_type != TYPE_NONE) begin
        type_next  = hdr_type;
        cnt_next   = '0;
        shift_next = '0;
        state_next = RECV;
      end else begin
        frame_err_next = 1'b1;
        err_code_next  = ERR_HDR;
        state_next     = IDLE;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_type  = out_type_reg;
  assign out_valid = out_valid_reg;
  assign frame_err = frame_err_reg;
  assign err_code  = err_code_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sm4_rx_framer.sv
// Self-checking bench for sm4_rx_framer: directed scenarios plus randomized
// frames, compared every cycle against a queue-based frame model.
module tb_sm4_rx_framer;

  localparam int CLK_F         = 50000000;
  localparam int UART_B        = 192000;
  localparam int TIMEOUT_BYTES = 4;
  localparam int TO            = TIMEOUT_BYTES * 10 * (CLK_F / UART_B);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_pdata = 8'h00;
  logic         rx_pdvalid = 1'b0;
  logic [127:0] out_data;
  logic [1:0]   out_type;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         frame_err;
  logic [1:0]   err_code;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm4_rx_framer #(
    .CLK_F(CLK_F), .UART_B(UART_B), .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_pdata(rx_pdata), .rx_pdvalid(rx_pdvalid),
    .out_data(out_data), .out_type(out_type), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [1:0] hdr_to_type(input logic [7:0] b);
    case (b)
      8'hA5:   return 2'b01;
      8'h5A:   return 2'b10;
      8'h3C:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int          m_mode;      // 0 idle, 1 collecting payload, 2 block waiting
  logic [7:0]  m_q[$];
  int          m_silent;
  logic [1:0]  m_type;
  logic        m_prev;
  logic [127:0] e_data;
  logic [1:0]  e_type, e_code;
  logic        e_valid, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_q.delete(); m_silent = 0; m_type = 2'b00; m_prev = 1'b0;
      e_data = '0; e_type = 2'b00; e_code = 2'b00; e_valid = 1'b0; e_err = 1'b0;
    end else begin
      logic acc, start;
      acc = rx_pdvalid && !m_prev;
      m_prev = rx_pdvalid;
      e_err = 1'b0;
      start = 1'b0;
      if (m_mode == 1) begin
        if (acc) begin
          m_q.push_back(rx_pdata);
          m_silent = 0;
          if (m_q.size() == 16) begin
            for (int i = 0; i < 16; i++) e_data[127-8*i -: 8] = m_q[i];
            e_type = m_type; e_valid = 1'b1; m_mode = 2;
          end
        end else if (m_silent == TO - 1) begin
          e_err = 1'b1; e_code = 2'b10; m_mode = 0;
        end else begin
          m_silent++;
        end
      end else if (m_mode == 2) begin
        if (out_ready) begin
          e_valid = 1'b0; e_type = 2'b00; m_mode = 0; start = acc;
        end else if (acc) begin
          e_err = 1'b1; e_code = 2'b11;
        end
      end else begin
        start = acc;
      end
      if (start) begin
        if (hdr_to_type(rx_pdata) != 2'b00) begin
          m_type = hdr_to_type(rx_pdata); m_mode = 1; m_q.delete(); m_silent = 0;
        end else begin
          e_err = 1'b1; e_code = 2'b01;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_out_valid", 128'(out_valid), 128'(e_valid));
      chk("cyc_out_type",  128'(out_type),  128'(e_type));
      chk("cyc_out_data",  out_data,        e_data);
      chk("cyc_frame_err", 128'(frame_err), 128'(e_err));
      chk("cyc_err_code",  128'(err_code),  128'(e_code));
      chk("cyc_busy",      128'(busy),      128'(m_mode != 0));
    end
  end

  // ---------------- transaction monitors ----------------
  int           blk_cnt = 0, err_cnt = 0;
  logic [127:0] last_data = '0;
  logic [1:0]   last_type = 2'b00, last_code = 2'b00;

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        blk_cnt++; last_data = out_data; last_type = out_type;
        $display("block   type=%0d data=%h", out_type, out_data);
      end
      if (frame_err) begin
        err_cnt++; last_code = err_code;
        $display("error   code=%0d", err_code);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pl [16];

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_pdata = b;
    rx_pdvalid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_pdvalid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int n, input int hold, input int gap);
    send_byte(hdr, hold, gap);
    for (int i = 0; i < n; i++) send_byte(pl[i], hold, gap);
  endtask

  function automatic logic [127:0] pl_block();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = pl[i];
    return r;
  endfunction

  task automatic rand_pl();
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int b0, e0;
    logic [127:0] held, lit;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_type", 128'(out_type), '0);
    chk("rst_out_valid", 128'(out_valid), '0);
    chk("rst_frame_err", 128'(frame_err), '0);
    chk("rst_err_code", 128'(err_code), '0);
    chk("rst_busy", 128'(busy), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // key frame 00..0F
    for (int i = 0; i < 16; i++) pl[i] = 8'(i);
    b0 = blk_cnt;
    send_frame(8'hA5, 16, 1, 2);
    repeat (3) @(negedge clk);
    chk("key_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("key_type", 128'(last_type), 128'(2'b01));
    chk("key_data", last_data, 128'h000102030405060708090A0B0C0D0E0F);

    // level held high for a full byte time
    for (int i = 0; i < 16; i++) pl[i] = 8'h11;
    b0 = blk_cnt; e0 = err_cnt;
    send_frame(8'h5A, 16, 2604, 1);
    repeat (3) @(negedge clk);
    lit = {16{8'h11}};
    chk("lvl_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("lvl_errors", 128'(err_cnt - e0), 128'(0));
    chk("lvl_type", 128'(last_type), 128'(2'b10));
    chk("lvl_data", last_data, lit);

    // bad header then decrypt frame
    e0 = err_cnt;
    send_byte(8'hFF, 1, 3);
    chk("badhdr_errs", 128'(err_cnt - e0), 128'(1));
    chk("badhdr_code", 128'(last_code), 128'(2'b01));
    chk("badhdr_busy", 128'(busy), 128'(0));
    rand_pl();
    b0 = blk_cnt;
    send_frame(8'h3C, 16, 1, 3);
    repeat (3) @(negedge clk);
    chk("dec_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("dec_type", 128'(last_type), 128'(2'b11));
    chk("dec_data", last_data, pl_block());

    // timeout after partial frame
    rand_pl();
    e0 = err_cnt;
    send_frame(8'h5A, 5, 1, 2);
    repeat (TO + 20) @(negedge clk);
    chk("to_errs", 128'(err_cnt - e0), 128'(1));
    chk("to_code", 128'(last_code), 128'(2'b10));
    chk("to_busy", 128'(busy), 128'(0));
    rand_pl();
    b0 = blk_cnt;
    send_frame(8'h5A, 16, 1, 2);
    repeat (3) @(negedge clk);
    chk("to_next_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("to_next_data", last_data, pl_block());

    // backpressure, overrun, then handshake coinciding with a header edge
    out_ready = 1'b0;
    rand_pl();
    send_frame(8'hA5, 16, 1, 2);
    repeat (3) @(negedge clk);
    chk("bp_valid", 128'(out_valid), 128'(1));
    chk("bp_data", out_data, pl_block());
    held = out_data;
    e0 = err_cnt;
    send_byte(8'hA5, 1, 3);
    chk("ovr_errs", 128'(err_cnt - e0), 128'(1));
    chk("ovr_code", 128'(last_code), 128'(2'b11));
    chk("ovr_data", out_data, held);
    chk("ovr_valid", 128'(out_valid), 128'(1));
    b0 = blk_cnt;
    rx_pdata = 8'hA5; rx_pdvalid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("hs_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("hs_block_data", last_data, held);
    chk("hs_busy", 128'(busy), 128'(1));
    chk("hs_valid", 128'(out_valid), 128'(0));
    rx_pdvalid = 1'b0;
    repeat (2) @(negedge clk);
    rand_pl();
    for (int i = 0; i < 16; i++) send_byte(pl[i], 1, 2);
    repeat (3) @(negedge clk);
    chk("hs_next_type", 128'(last_type), 128'(2'b01));
    chk("hs_next_data", last_data, pl_block());

    // async reset mid-frame
    rand_pl();
    send_frame(8'h3C, 8, 1, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), '0);
    chk("arst_valid", 128'(out_valid), '0);
    chk("arst_type", 128'(out_type), '0);
    chk("arst_data", out_data, '0);
    chk("arst_code", 128'(err_code), '0);
    chk("arst_err", 128'(frame_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rand_pl();
    b0 = blk_cnt;
    send_frame(8'hA5, 16, 1, 2);
    repeat (3) @(negedge clk);
    chk("arst_next_blocks", 128'(blk_cnt - b0), 128'(1));
    chk("arst_next_data", last_data, pl_block());

    // randomized traffic; the per-cycle model does the checking
    for (int f = 0; f < 20; f++) begin
      logic [7:0] hdr;
      case ($urandom_range(0, 4))
        0: hdr = 8'hA5;
        1: hdr = 8'h5A;
        2: hdr = 8'h3C;
        default: hdr = 8'($urandom_range(0, 255));
      endcase
      rand_pl();
      out_ready = ($urandom_range(0, 9) < 7);
      send_byte(hdr, int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
      for (int i = 0; i < 16; i++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        send_byte(pl[i], int'($urandom_range(1, 3)), int'($urandom_range(1, 6)));
      end
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_rx_framer.md
Name: sm4_rx_framer

Overview:
Sits directly downstream of the UART byte receiver and upstream of the SM4 core. Consumes the receiver's byte stream (rx_pdata/rx_pdvalid) and parses frames of 1 header byte plus 16 payload bytes. Each complete frame is presented as one 128-bit block with a type tag (key / encrypt-data / decrypt-data) over a valid/ready handshake. Malformed, stalled or overrun frames are reported on an error pulse and discarded.

Parameters:
CLK_F, 50000000, main clock frequency in Hz
UART_B, 9600, UART baud rate
TIMEOUT_BYTES, 4, inter-byte timeout in byte times; TIMEOUT_CYC = TIMEOUT_BYTES*10*(CLK_F/UART_B)
HDR_KEY, 8'hA5, header byte for key frame
HDR_ENC, 8'h5A, header byte for encrypt-data frame
HDR_DEC, 8'h3C, header byte for decrypt-data frame

Ports:
clk  input  1  main clock
rst_n  input  1  reset, asynchronous, active-low
rx_pdata  input  8  received byte; valid while rx_pdvalid high
rx_pdvalid  input  1  byte-valid level; may stay high for many cycles per byte
out_data  output  128  assembled block; first payload byte in [127:120]
out_type  output  2  01 key, 10 encrypt, 11 decrypt, 00 none
out_valid  output  1  block available
out_ready  input  1  SM4 side accepts block
frame_err  output  1  one-cycle error pulse
err_code  output  2  01 bad header, 10 timeout, 11 overrun; held until next error
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; out_data 0, out_type 00, out_valid 0, frame_err 0, err_code 00, busy 0; byte counter 0, timeout counter 0; rx_pdvalid edge register 0.
- Byte acceptance: rx_pdvalid is registered; a byte is accepted only on its rising edge (rx_pdvalid=1, previous=0), sampling rx_pdata that cycle. A level held high accepts exactly one byte.
- IDLE: on accepted byte: HDR_KEY/HDR_ENC/HDR_DEC -> latch type, byte counter=0, timeout counter=0, go RECV. Other value -> frame_err pulse, err_code=01, stay IDLE.
- RECV: each accepted byte shifts in: shift reg <= {shift[119:0], byte}; counter++. The accepted byte with counter==15 -> out_data <= {shift[119:0], byte}, out_type <= latched type, out_valid=1 next cycle, go HOLD. Latency: out_valid rises 1 cycle after the 16th payload byte edge.
- Timeout: in RECV the counter increments every cycle and clears on each accepted byte; reaching TIMEOUT_CYC-1 -> frame_err pulse, err_code=10, partial data discarded, IDLE. Counter idle (0) outside RECV; 24-bit width, no wrap.
- HOLD: out_data/out_type/out_valid stable until out_valid&&out_ready; then out_valid=0, out_type=00, IDLE (out_data keeps last value).
- HOLD overrun: accepted byte without out_ready same cycle -> byte dropped, frame_err pulse, err_code=11, remain HOLD with block intact.
- Simultaneous handshake and accepted byte in HOLD: handshake completes and the byte is processed as a header exactly as in IDLE (may go directly to RECV or flag bad header).
- Timeout expiry and accepted byte in same cycle: byte wins, timeout counter clears.
- frame_err is a single-cycle pulse; never asserted on two consecutive cycles from one event.
- No RECV->RECV restart on header values mid-frame; header values inside payload are data.

Decomposition:
- Package sm4_uart_pkg: header constants, out_type encodings (TYPE_NONE/KEY/ENC/DEC), err_code encodings, state enum (IDLE, RECV, HOLD), TIMEOUT_CYC computation.
- One sub-module: sm4_byte_timeout (clear, enable, expire pulse; parameter TIMEOUT_CYC). Edge detect and shift register stay in top.

Test Plan:
- Key frame: A5 then bytes 00..0F, out_ready=1 -> out_valid one cycle, out_type=01, out_data=128'h000102030405060708090A0B0C0D0E0F.
- Level hold: rx_pdvalid held high 2604 cycles per byte, encrypt frame 5A + 16x 8'h11 -> exactly one block, out_type=10, out_data all 8'h11; no extra bytes counted.
- Bad header: byte 8'hFF in IDLE -> frame_err 1-cycle, err_code=01, busy stays 0; following 3C + 16 bytes -> out_type=11.
- Timeout: 5A + 5 bytes then silence > TIMEOUT_CYC -> frame_err, err_code=10, busy 0; next full frame assembles correctly with no stale bytes.
- Backpressure/overrun: complete frame, out_ready=0, send byte 8'hA5 -> err_code=11, out_data unchanged; raise out_ready on a cycle coinciding with an A5 edge -> handshake done and state RECV (busy=1).
- Async reset mid-RECV after 8 payload bytes -> all outputs at reset values immediately; next frame from scratch yields correct block.
